// File: rtl/cnn_core_sched.sv
// cnn_core_sched: walks every stride-1 window of an IXxIY fmap under credit flow control and signals frame done.
// Optional CNN_SCHED_PERF_EN enables the RUN/DRAIN cycle counter on o_perf_cycles.
module cnn_core_sched #(
    parameter int IX      = 5,
    parameter int IY      = 5,
    parameter int KX      = 3,
    parameter int KY      = 3,
    parameter int CREDIT  = 4,
    parameter int ADDR_BW = 16,
    parameter int CNT_BW  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_soft_reset,
    input  logic               i_start,
    output logic               o_idle,
    output logic               o_done,
    output logic               o_win_valid,
    output logic [ADDR_BW-1:0] o_win_x,
    output logic [ADDR_BW-1:0] o_win_y,
    output logic [ADDR_BW-1:0] o_win_addr,
    input  logic               i_core_valid,
    input  logic               i_credit_ret,
    output logic [CNT_BW-1:0]  o_outstanding,
    output logic [CNT_BW-1:0]  o_perf_cycles
);
    localparam int OX = IX - KX + 1;
    localparam int OY = IY - KY + 1;
    localparam logic [CNT_BW-1:0] NWIN = CNT_BW'(OX * OY);
    localparam logic [CNT_BW-1:0] NCRED = CNT_BW'(CREDIT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic clr, start, issue, last, row_end, ret_ok, busy;
    logic [ADDR_BW-1:0] cx, cy, caddr;
    logic [CNT_BW-1:0] results;

    assign clr     = !reset_n || i_soft_reset;
    assign start   = state == IDLE && i_start;
    assign busy    = state == RUN || state == DRAIN;
    assign row_end = cx == ADDR_BW'(OX - 1);
    assign last    = row_end && cy == ADDR_BW'(OY - 1);
    assign issue   = (state == RUN || start) && o_outstanding < NCRED;
    assign ret_ok  = i_credit_ret && o_outstanding != '0;
    assign o_idle  = state == IDLE;
    assign o_done  = state == DONE;

    always_comb begin
        state_nx = state;
        state_nx = (start || state == RUN) ? (issue && last ? DRAIN : RUN) :
                   state == DRAIN ? (results == NWIN ? DONE : DRAIN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state         <= IDLE;
            o_win_valid   <= 1'b0;
            o_win_x       <= '0;
            o_win_y       <= '0;
            o_win_addr    <= '0;
            cx            <= '0;
            cy            <= '0;
            caddr         <= '0;
            o_outstanding <= '0;
            results       <= '0;
        end else begin
            state       <= state_nx;
            o_win_valid <= issue;
            if (issue) begin
                o_win_x    <= cx;
                o_win_y    <= cy;
                o_win_addr <= caddr;
                cx         <= row_end ? '0 : cx + 1'b1;
                cy         <= last ? '0 : row_end ? cy + 1'b1 : cy;
                // row wrap skips the KX-1 columns that no window can start in
                caddr      <= last ? '0 : row_end ? caddr + ADDR_BW'(KX) : caddr + 1'b1;
            end
            o_outstanding <= o_outstanding + CNT_BW'(issue) - CNT_BW'(ret_ok);
            results <= start ? '0 : (busy && i_core_valid && results != NWIN) ? results + 1'b1 : results;
        end
    end

`ifdef CNN_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (clr || start)
            o_perf_cycles <= '0;
        else if (busy && o_perf_cycles != '1)
            o_perf_cycles <= o_perf_cycles + 1'b1;
    end
`else
    assign o_perf_cycles = '0;
`endif
endmodule

// File: tb/tb_cnn_core_sched.sv
// tb_cnn_core_sched: randomized scoreboard bench for cnn_core_sched (IX=IY=5, KX=KY=3, CREDIT=4).
// The expected window list is generated per frame from plain nested loops; a negedge monitor pops and compares.
module tb_cnn_core_sched;
    localparam int IX = 5, IY = 5, KX = 3, KY = 3, CREDIT = 4;
    localparam int OX = IX - KX + 1, OY = IY - KY + 1, NWIN = OX * OY;

    logic clk = 0, reset_n = 0, i_soft_reset = 0, i_start = 0, i_core_valid = 0, i_credit_ret = 0;
    logic o_idle, o_done, o_win_valid;
    logic [15:0] o_win_x, o_win_y, o_win_addr, o_outstanding, o_perf_cycles;

    typedef struct {int x; int y; int a;} win_t;
    win_t win_q[$];
    int checks = 0, failures = 0;
    int win_seen = 0, res_sent = 0, done_exp = 0, fcyc = 0, last_len = 0;
    bit in_frame = 0, done_seen = 0;

    cnn_core_sched #(.IX(IX), .IY(IY), .KX(KX), .KY(KY), .CREDIT(CREDIT), .ADDR_BW(16), .CNT_BW(16)) dut (
        .clk(clk), .reset_n(reset_n), .i_soft_reset(i_soft_reset), .i_start(i_start),
        .o_idle(o_idle), .o_done(o_done), .o_win_valid(o_win_valid), .o_win_x(o_win_x), .o_win_y(o_win_y),
        .o_win_addr(o_win_addr), .i_core_valid(i_core_valid), .i_credit_ret(i_credit_ret),
        .o_outstanding(o_outstanding), .o_perf_cycles(o_perf_cycles)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int exp_perf(int n);
`ifdef CNN_SCHED_PERF_EN
        return n;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (o_win_valid) begin
            win_seen++;
            if (win_q.size() == 0) chk("win_unexpected", 1, 0);
            else begin
                win_t w;
                w = win_q.pop_front();
                chk("win_x", int'(o_win_x), w.x);
                chk("win_y", int'(o_win_y), w.y);
                chk("win_addr", int'(o_win_addr), w.a);
            end
            chk("outstanding_le_credit", int'(o_outstanding <= 16'(CREDIT)), 1);
        end
        if (in_frame) begin
            if (o_done) begin
                chk("perf_at_done", int'(o_perf_cycles), exp_perf(fcyc));
                last_len = fcyc;
                in_frame = 0;
            end else fcyc++;
        end
        if (o_done) begin
            done_seen = 1;
            chk("done_expected", int'(done_exp > 0), 1);
            chk("results_at_done", res_sent, NWIN);
            if (done_exp > 0) done_exp--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(bit hold);
        i_start = 1;
        tick();
        i_start = hold;
        for (int y = 0; y < OY; y++)
            for (int x = 0; x < OX; x++)
                win_q.push_back('{x, y, y * IX + x});
        done_exp++;
        in_frame = 1;
        fcyc = 0;
        done_seen = 0;
        win_seen = 0;
        res_sent = 0;
    endtask

    // emulates cnn_core and the result buffer until the frame completes
    task automatic run_frame(int ret_pct, bit hold);
        for (int c = 0; c < 400 && !done_seen; c++) begin
            tick();
            i_start = hold && !done_seen;
            i_core_valid = !done_seen && win_seen > res_sent && $urandom_range(0, 1) == 1;
            if (i_core_valid) res_sent++;
            i_credit_ret = $urandom_range(0, 99) < ret_pct;
        end
        i_start = 0;
        i_core_valid = 0;
        i_credit_ret = 0;
        chk("frame_completed", int'(done_seen), 1);
        chk("idle_after_done", int'(o_idle), 1);
    endtask

    task automatic flush();
        i_credit_ret = 1;
        repeat (CREDIT + 2) tick();
        i_credit_ret = 0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        chk("rst_idle", int'(o_idle), 1);
        chk("rst_done", int'(o_done), 0);
        chk("rst_valid", int'(o_win_valid), 0);
        chk("rst_addr", int'(o_win_addr), 0);
        chk("rst_outstanding", int'(o_outstanding), 0);
        chk("rst_perf", int'(o_perf_cycles), 0);
        reset_n = 1;
        tick();

        start_frame(0);
        run_frame(100, 0);
        repeat (3) tick();
        chk("perf_held_idle", int'(o_perf_cycles), exp_perf(last_len));
        flush();

        start_frame(0);
        repeat (10) tick();
        chk("stall_windows", win_seen, CREDIT);
        chk("stall_outstanding", int'(o_outstanding), CREDIT);
        chk("stall_valid", int'(o_win_valid), 0);
        i_credit_ret = 1;
        tick();
        i_credit_ret = 0;
        repeat (3) tick();
        chk("one_return_windows", win_seen, CREDIT + 1);
        chk("one_return_outstanding", int'(o_outstanding), CREDIT);
        i_credit_ret = 1;
        repeat (2) tick();
        chk("ret_issue_outstanding", int'(o_outstanding), CREDIT - 1);
        chk("ret_issue_valid", int'(o_win_valid), 1);
        run_frame(50, 0);
        flush();

        start_frame(0);
        i_credit_ret = 1;
        for (int c = 0; c < 50 && win_seen < 5; c++) begin
            @(negedge clk);
            #1;
        end
        chk("abort_point", win_seen, 5);
        i_credit_ret = 0;
        i_soft_reset = 1;
        tick();
        i_soft_reset = 0;
        win_q.delete();
        done_exp = 0;
        in_frame = 0;
        chk("soft_idle", int'(o_idle), 1);
        chk("soft_valid", int'(o_win_valid), 0);
        chk("soft_x", int'(o_win_x), 0);
        chk("soft_y", int'(o_win_y), 0);
        chk("soft_addr", int'(o_win_addr), 0);
        chk("soft_outstanding", int'(o_outstanding), 0);
        chk("soft_perf", int'(o_perf_cycles), 0);
        i_soft_reset = 1;
        i_start = 1;
        tick();
        i_soft_reset = 0;
        i_start = 0;
        repeat (2) tick();
        chk("soft_beats_start", int'(o_idle), 1);
        chk("soft_no_window", int'(o_win_valid), 0);
        start_frame(0);
        run_frame(70, 0);
        flush();

        i_core_valid = 1;
        repeat (2) tick();
        i_core_valid = 0;
        chk("idle_core_valid_ignored", int'(o_idle), 1);
        start_frame(1);
        run_frame(60, 1);
        flush();

        for (int f = 0; f < 3; f++) begin
            start_frame(0);
            run_frame($urandom_range(20, 90), 0);
        end
        repeat (4) tick();
        chk("final_perf_held", int'(o_perf_cycles), exp_perf(last_len));
        chk("final_no_pending_windows", win_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
